inv_round_key_seq: RTL
======================

Name: inv_round_key_seq

Overview:
- Round-key buffer and reverse-order AddRoundKey stage for the AES decryption datapath.
- The key expansion writes round keys 0..NR in forward order.
- The decryption round loop then streams state words in, one per round. Each is XORed with round keys NR, NR-1, ..., 0 and returned through a registered valid/ready output.
- It sits between the key expansion and the inverse round logic, mirroring the encrypt-side add-round-key stage.

Parameters:
- NR, 10: number of cipher rounds; NR+1 keys are stored (10/12/14 for AES-128/192/256 round counts).
- DW, 128: state and round-key width in bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_wr_valid  input  1  round-key write strobe; one key per asserted cycle.
- key_wr_data  input  DW  round key, written in order 0..NR.
- key_ready  output  1  high when all NR+1 keys are loaded.
- in_valid  input  1  state word offered.
- in_ready  output  1  stage can accept a state word.
- in_data  input  DW  state word for the current round.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DW  in_data XOR key[rptr].
- out_last  output  1  result used key 0 (final decryption AddRoundKey).
- out_round  output  4  index of the key applied to out_data.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_last=0, out_round=0, key_ready=0.
  - Write counter wcnt=0, read pointer rptr=NR, FSM in EMPTY.
  - Key storage contents are don't-care, except under the optional feature below.
- FSM states EMPTY, LOADING, READY:
  - EMPTY: a key_wr_valid cycle stores key[0], sets wcnt=1 and moves to LOADING.
  - LOADING: each key_wr_valid stores key[wcnt] and increments wcnt. The write of key[NR] moves to READY with key_ready=1 on the next cycle.
  - READY: key_wr_valid restarts a load. That cycle's key is stored as key[0], wcnt=1, the FSM goes to LOADING, key_ready drops next cycle and rptr resets to NR.
- in_ready = (state==READY) && (!out_valid || out_ready).
  - Forced 0 in EMPTY/LOADING and in the cycle where key_wr_valid is high in READY.
- Transfer when in_valid && in_ready. Next cycle:
  - out_data = in_data ^ key[rptr], out_round = rptr, out_last = (rptr==0), out_valid = 1.
  - Latency is 1 cycle; full throughput of 1 word per cycle when out_ready is held high.
- rptr after each transfer: decrements; if rptr==0 it wraps to NR, so the next block starts at key NR.
- Output register:
  - out_valid clears on out_ready && !new transfer.
  - out_data, out_round and out_last hold stable while out_valid && !out_ready.
- A key reload while a result is pending does not alter the pending result. The result is still delivered; only rptr is reset.
- A reset mid-block discards the partial block; software reloads the keys.
- out_round is 4 bits; NR > 15 is illegal.

Optional Feature:
- Macro KEY_ZEROIZE_EN.
- Defined:
  - Extra input port zeroize (1 bit).
  - When high for one cycle, all NR+1 key entries and out_data are cleared to 0 on the next edge.
  - FSM goes to EMPTY, key_ready=0, wcnt=0, rptr=NR, and out_valid drops.
  - Zeroize wins over a simultaneous key write or transfer.
  - Reset also clears all key storage to 0.
- Not defined: no zeroize port; storage is not cleared at reset.

Test Plan:
1. Load 11 keys key[i]={16{8'(i+1)}}, then stream 11 zero state words with out_ready=1 -> out_data = key[10]..key[0] in order, out_round 10..0, out_last high only on the 11th result, one result per cycle.
2. in_valid=1 during LOADING after 5 key writes -> in_ready=0 and no output. After the 11th key write, key_ready=1 on the next cycle and the first transfer uses key[10].
3. Backpressure: out_ready=0 for 3 cycles with in_data=128'hFFFF... -> out_valid stays 1, out_data holds ~key[10], in_ready=0. Releasing out_ready completes with no loss or duplication.
4. Stream 15 words (one full block plus 4) -> out_round sequence 10..0, then 10, 9, 8, 7, confirming wrap.
5. Reload the keys after 3 transfers while one result is pending -> the pending result (key[8]) is still delivered. After the reload, the first transfer uses the new key[10].
6. Assert rst asynchronously mid-stream -> all outputs go to 0 immediately and key_ready=0. With KEY_ZEROIZE_EN, a zeroize pulse gives key_ready=0, and a subsequent reload of all-zero keys passes in_data through unchanged.

Source files
------------

// File: rtl/inv_round_key_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_round_key_seq
// Brief    : Round-key buffer with reverse-order AddRoundKey for AES decrypt.
//            Keys 0..NR are written in forward order. The stored keys are then
//            applied to a stream of state words in the order NR..0, and the
//            results leave through a registered valid/ready output.
// Options  : KEY_ZEROIZE_EN - adds a zeroize input. It clears the key store
//            and the output data, and returns the stage to EMPTY.
// Revision : 1.0 - initial release
// ============================================================================
module inv_round_key_seq #(
   parameter int NR = 10,   // cipher rounds; NR+1 keys stored, must be <= 15
   parameter int DW = 128   // state / round-key width
) (
   input  logic          clk,
   input  logic          rst,
`ifdef KEY_ZEROIZE_EN
   input  logic          zeroize,
`endif
   input  logic          key_wr_valid,
   input  logic [DW-1:0] key_wr_data,
   output logic          key_ready,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [3:0]    out_round
);

   localparam logic [3:0] c_NR_IDX = 4'(NR);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_LOADING = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_wcnt;
   logic [3:0]      w_wcnt_nxt;
   logic [3:0]      r_rptr;
   logic [3:0]      w_wr_idx;
   logic [DW-1:0]   r_key [0:NR];
   logic            r_out_valid;
   logic [DW-1:0]   r_out_data;
   logic            r_out_last;
   logic [3:0]      r_out_round;
   logic            w_zeroize;
   logic            w_in_ready;
   logic            w_xfer;

`ifdef KEY_ZEROIZE_EN
   assign w_zeroize = zeroize;
`else
   assign w_zeroize = 1'b0;
`endif

   // A load always starts at key[0]. Only a load that is already in
   // progress uses the running write counter.
   assign w_wr_idx = (r_state == ST_LOADING) ? r_wcnt : 4'd0;

   // Accept a word only when the keys are complete and no reload or zeroize
   // is in progress. The output slot must be free or draining this cycle.
   assign w_in_ready = (r_state == ST_READY) && !key_wr_valid && !w_zeroize &&
                       (!r_out_valid || out_ready);
   assign w_xfer     = in_valid && w_in_ready;

   assign in_ready  = w_in_ready;
   assign key_ready = (r_state == ST_READY);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_round = r_out_round;

`ifdef KEY_ZEROIZE_EN
   // Key store: cleared by reset and by zeroize, otherwise written in order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) r_key[i] <= '0;
      end else if (w_zeroize) begin
         for (int i = 0; i <= NR; i++) r_key[i] <= '0;
      end else if (key_wr_valid) begin
         r_key[w_wr_idx] <= key_wr_data;
      end
   end
`else
   // Key store: plain write port. The contents after reset do not matter,
   // because the stage is not ready until a full load has completed.
   always_ff @(posedge clk) begin
      if (key_wr_valid) begin
         r_key[w_wr_idx] <= key_wr_data;
      end
   end
`endif

   // Load state and write counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_wcnt  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   // Load sequencing: EMPTY -> LOADING -> READY. Any write while READY
   // restarts the load at key[0].
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      case (r_state)
         ST_EMPTY: begin
            if (key_wr_valid) begin
               w_state_nxt = ST_LOADING;
               w_wcnt_nxt  = 4'd1;
            end
         end
         ST_LOADING: begin
            if (key_wr_valid) begin
               w_wcnt_nxt = r_wcnt + 4'd1;
               if (r_wcnt == c_NR_IDX) begin
                  w_state_nxt = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (key_wr_valid) begin
               w_state_nxt = ST_LOADING;
               w_wcnt_nxt  = 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
            w_wcnt_nxt  = 4'd0;
         end
      endcase
      if (w_zeroize) begin
         w_state_nxt = ST_EMPTY;
         w_wcnt_nxt  = 4'd0;
      end
   end

   // Read pointer walks NR..0 and then wraps to NR for the next block. Any
   // key write rewinds it, so a reloaded schedule always starts at key NR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr <= c_NR_IDX;
      end else if (w_zeroize || key_wr_valid) begin
         r_rptr <= c_NR_IDX;
      end else if (w_xfer) begin
         r_rptr <= (r_rptr == 4'd0) ? c_NR_IDX : (r_rptr - 4'd1);
      end
   end

   // Output register: loaded on a transfer and held while stalled. It
   // empties when the result is taken and no new word replaces it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_round <= 4'd0;
      end else if (w_zeroize) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_round <= 4'd0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= in_data ^ r_key[r_rptr];
         r_out_last  <= (r_rptr == 4'd0);
         r_out_round <= r_rptr;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
